// File: rtl/xyolo_macc_pipe.sv
// Streaming signed MACC / max-pool unit with bias seeding, shift, activation and saturation.
// Each group of cfg_len accepted operand pairs reduces to one output word; cfg_groups words per run.
module xyolo_macc_pipe #(
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned OUT_W   = 16,
  parameter int unsigned GUARD_W = 8,
  parameter int unsigned LEN_W   = 12,
  parameter int unsigned SHIFT_W = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               run,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic [LEN_W-1:0]   cfg_groups,
  input  logic [SHIFT_W-1:0] cfg_shift,
  input  logic               cfg_bias_en,
  input  logic [1:0]         cfg_act,
  input  logic               cfg_sat_en,
  input  logic               cfg_maxpool,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [DATA_W-1:0]  op_a,
  input  logic [DATA_W-1:0]  op_b,
  input  logic [DATA_W-1:0]  bias,
  output logic               out_valid,
  output logic [OUT_W-1:0]   out_data,
  output logic               busy,
  output logic               done
);

  localparam int unsigned PROD_W = 2 * DATA_W;
  localparam int unsigned ACC_W  = PROD_W + GUARD_W;
  localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DRAIN, ST_DONE} state_e;

  state_e               state_q, state_d;
  logic [LEN_W-1:0]     elem_q, elem_d, grp_q, grp_d;
  logic [LEN_W-1:0]     len_q, groups_q;
  logic [SHIFT_W-1:0]   shift_q;
  logic [1:0]           act_q;
  logic                 bias_en_q, sat_en_q, maxpool_q;
  logic                 accept, elem_last, grp_last, pipe_busy;

  logic                     s1_v_q, s1_first_q, s1_last_q;
  logic signed [DATA_W-1:0] s1_a_q, s1_b_q, s1_bias_q;
  logic                     s2_v_q, s2_first_q, s2_last_q;
  logic signed [PROD_W-1:0] s2_val_q, s2_val_d;
  logic signed [ACC_W-1:0]  s2_seed_q, s2_seed_d;
  logic                     s3_v_q, s3_last_q;
  logic signed [ACC_W-1:0]  acc_q, acc_d, s3_in;
  logic signed [ACC_W-1:0]  post_shift, post_act;
  logic                     out_valid_q, out_valid_d;
  logic [OUT_W-1:0]         out_data_q, out_data_d, post_res;

  assign in_ready  = (state_q == ST_RUN);
  assign busy      = (state_q != ST_IDLE);
  assign done      = (state_q == ST_DONE);
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

  assign accept    = in_valid & in_ready;
  assign elem_last = (elem_q == len_q - LEN_W'(1));
  assign grp_last  = (grp_q == groups_q - LEN_W'(1));
  assign pipe_busy = s1_v_q | s2_v_q | s3_v_q | out_valid_q;

  // Run sequencing and element/group counting
  always_comb begin
    state_d = state_q;
    elem_d  = elem_q;
    grp_d   = grp_q;
    case (state_q)
      ST_IDLE: begin
        elem_d = '0;
        grp_d  = '0;
        if (run) begin
          if (cfg_len == '0 || cfg_groups == '0) state_d = ST_DONE;
          else                                   state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (accept) begin
          if (elem_last) begin
            elem_d = '0;
            grp_d  = grp_q + LEN_W'(1);
            if (grp_last) state_d = ST_DRAIN;
          end else begin
            elem_d = elem_q + LEN_W'(1);
          end
        end
      end
      ST_DRAIN: if (!pipe_busy) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      elem_q  <= '0;
      grp_q   <= '0;
    end else begin
      state_q <= state_d;
      elem_q  <= elem_d;
      grp_q   <= grp_d;
    end
  end

  // Configuration is frozen for the whole run
  always_ff @(posedge clk) begin
    if (rst) begin
      len_q     <= '0;
      groups_q  <= '0;
      shift_q   <= '0;
      act_q     <= '0;
      bias_en_q <= 1'b0;
      sat_en_q  <= 1'b0;
      maxpool_q <= 1'b0;
    end else if (state_q == ST_IDLE && run) begin
      len_q     <= cfg_len;
      groups_q  <= cfg_groups;
      shift_q   <= cfg_shift;
      act_q     <= cfg_act;
      bias_en_q <= cfg_bias_en;
      sat_en_q  <= cfg_sat_en;
      maxpool_q <= cfg_maxpool;
    end
  end

  // S2: product (or passthrough of op_a for max-pool) and pre-shifted seed
  always_comb begin
    s2_val_d  = maxpool_q ? PROD_W'(s1_a_q) : PROD_W'(s1_a_q) * PROD_W'(s1_b_q);
    s2_seed_d = '0;
    if (bias_en_q) s2_seed_d = ACC_W'(s1_bias_q) <<< shift_q;
  end

  // S3: accumulate or running maximum; accumulator wraps silently
  always_comb begin
    s3_in = ACC_W'(s2_val_q);
    acc_d = acc_q;
    if (s2_v_q) begin
      if (maxpool_q) acc_d = (s2_first_q || s3_in > acc_q) ? s3_in : acc_q;
      else           acc_d = (s2_first_q ? s2_seed_q : acc_q) + s3_in;
    end
  end

  // S4: shift, activation, then saturate or truncate
  always_comb begin
    post_shift = acc_q >>> shift_q;
    case (act_q)
      2'd1:    post_act = post_shift[ACC_W-1] ? (post_shift >>> 3) : post_shift;
      2'd2:    post_act = post_shift[ACC_W-1] ? '0 : post_shift;
      default: post_act = post_shift;
    endcase
    post_res = post_act[OUT_W-1:0];
    if (sat_en_q) begin
      if (post_act > SAT_MAX)      post_res = SAT_MAX[OUT_W-1:0];
      else if (post_act < SAT_MIN) post_res = SAT_MIN[OUT_W-1:0];
    end
    out_valid_d = s3_v_q & s3_last_q;
    out_data_d  = out_valid_d ? post_res : out_data_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_v_q      <= 1'b0;
      s1_first_q  <= 1'b0;
      s1_last_q   <= 1'b0;
      s2_v_q      <= 1'b0;
      s2_first_q  <= 1'b0;
      s2_last_q   <= 1'b0;
      s3_v_q      <= 1'b0;
      s3_last_q   <= 1'b0;
      acc_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      s1_v_q      <= accept;
      s1_first_q  <= (elem_q == '0);
      s1_last_q   <= elem_last;
      s2_v_q      <= s1_v_q;
      s2_first_q  <= s1_first_q;
      s2_last_q   <= s1_last_q;
      s3_v_q      <= s2_v_q;
      s3_last_q   <= s2_last_q;
      acc_q       <= acc_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  // Datapath registers without reset; qualified by the valid pipeline
  always_ff @(posedge clk) begin
    if (accept) begin
      s1_a_q    <= $signed(op_a);
      s1_b_q    <= $signed(op_b);
      s1_bias_q <= $signed(bias);
    end
    if (s1_v_q) begin
      s2_val_q  <= s2_val_d;
      s2_seed_q <= s2_seed_d;
    end
  end

endmodule

// File: tb/tb_xyolo_macc_pipe.sv
// Self-checking bench for xyolo_macc_pipe: directed cases from the plan plus randomized jobs
// checked against an integer reference model of whole groups.
module tb_xyolo_macc_pipe;
  localparam int unsigned DATA_W  = 16;
  localparam int unsigned OUT_W   = 16;
  localparam int unsigned GUARD_W = 8;
  localparam int unsigned LEN_W   = 12;
  localparam int unsigned SHIFT_W = 6;
  localparam int unsigned ACC_W   = 2 * DATA_W + GUARD_W;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               run = 1'b0;
  logic [LEN_W-1:0]   cfg_len = '0;
  logic [LEN_W-1:0]   cfg_groups = '0;
  logic [SHIFT_W-1:0] cfg_shift = '0;
  logic               cfg_bias_en = 1'b0;
  logic [1:0]         cfg_act = '0;
  logic               cfg_sat_en = 1'b0;
  logic               cfg_maxpool = 1'b0;
  logic               in_valid = 1'b0;
  logic               in_ready;
  logic [DATA_W-1:0]  op_a = '0;
  logic [DATA_W-1:0]  op_b = '0;
  logic [DATA_W-1:0]  bias = '0;
  logic               out_valid;
  logic [OUT_W-1:0]   out_data;
  logic               busy;
  logic               done;

  xyolo_macc_pipe #(
    .DATA_W(DATA_W), .OUT_W(OUT_W), .GUARD_W(GUARD_W), .LEN_W(LEN_W), .SHIFT_W(SHIFT_W)
  ) dut (
    .clk(clk), .rst(rst), .run(run),
    .cfg_len(cfg_len), .cfg_groups(cfg_groups), .cfg_shift(cfg_shift),
    .cfg_bias_en(cfg_bias_en), .cfg_act(cfg_act), .cfg_sat_en(cfg_sat_en),
    .cfg_maxpool(cfg_maxpool), .in_valid(in_valid), .in_ready(in_ready),
    .op_a(op_a), .op_b(op_b), .bias(bias),
    .out_valid(out_valid), .out_data(out_data), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Job description, observed results and expected results
  int c_len, c_groups, c_shift, c_bias_en, c_act, c_sat, c_mp;
  int ja[$], jb[$], jbias[$];
  logic [OUT_W-1:0] got_d[$];
  int got_c[$], done_c[$], lastacc[$];
  logic [OUT_W-1:0] exp_q[$];
  logic ready_after;
  int n_cmp = 0;
  int n_err = 0;

  always @(posedge clk) begin
    #1;
    if (out_valid === 1'b1) begin
      got_d.push_back(out_data);
      got_c.push_back(cyc);
    end
    if (done === 1'b1) done_c.push_back(cyc);
  end

  function automatic int rnd16();
    logic [15:0] r;
    r = 16'($urandom);
    return int'($signed(r));
  endfunction

  function automatic longint wrap_acc(input longint x);
    return (x <<< (64 - ACC_W)) >>> (64 - ACC_W);
  endfunction

  function automatic logic [OUT_W-1:0] post_model(input longint acc);
    longint r, mx, mn;
    r  = acc >>> c_shift;
    if (c_act == 1 && r < 0) r = r >>> 3;
    if (c_act == 2 && r < 0) r = 0;
    mx = (longint'(1) <<< (OUT_W - 1)) - 1;
    mn = -mx - 1;
    if (c_sat != 0) begin
      if (r > mx) r = mx;
      if (r < mn) r = mn;
    end
    return r[OUT_W-1:0];
  endfunction

  task automatic build_exp();
    longint acc, seed;
    int i;
    exp_q.delete();
    acc = 0;
    for (int g = 0; g < c_groups; g++) begin
      for (int e = 0; e < c_len; e++) begin
        i = g * c_len + e;
        if (c_mp != 0) begin
          if (e == 0 || longint'(ja[i]) > acc) acc = longint'(ja[i]);
        end else begin
          seed = (c_bias_en != 0) ? wrap_acc(longint'(jbias[g * c_len]) <<< c_shift) : 0;
          acc  = wrap_acc(((e == 0) ? seed : acc) + longint'(ja[i]) * longint'(jb[i]));
        end
      end
      if (c_len > 0) exp_q.push_back(post_model(acc));
    end
  endtask

  task automatic start_run();
    cfg_len     = LEN_W'(c_len);
    cfg_groups  = LEN_W'(c_groups);
    cfg_shift   = SHIFT_W'(c_shift);
    cfg_bias_en = (c_bias_en != 0);
    cfg_act     = 2'(c_act);
    cfg_sat_en  = (c_sat != 0);
    cfg_maxpool = (c_mp != 0);
    got_d.delete(); got_c.delete(); done_c.delete(); lastacc.delete();
    @(negedge clk); run = 1'b1;
    @(negedge clk); run = 1'b0;
  endtask

  task automatic run_job(input int gap_pct);
    int total, t, g;
    total = c_len * c_groups;
    start_run();
    for (int i = 0; i < total; i++) begin
      g = 0;
      while (g < 4 && $urandom_range(99) < gap_pct) begin
        in_valid = 1'b0; g++; @(negedge clk);
      end
      in_valid = 1'b1;
      op_a = DATA_W'(ja[i]); op_b = DATA_W'(jb[i]); bias = DATA_W'(jbias[i]);
      t = 0;
      while (in_ready !== 1'b1 && t < 50) begin t++; @(negedge clk); end
      if (t >= 50) begin
        n_cmp++; n_err++;
        $display("FAIL accept_timeout: in_ready=%b required 1 at element %0d", in_ready, i);
        break;
      end
      if (i % c_len == c_len - 1) lastacc.push_back(cyc);
      @(negedge clk);
    end
    in_valid = 1'b0;
    ready_after = in_ready;
    t = 0;
    while (done_c.size() == 0 && t < 300) begin t++; @(negedge clk); end
    if (t >= 300) begin
      n_cmp++; n_err++;
      $display("FAIL done_timeout: done never seen, required within 300 cycles");
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL reset_in_ready: got %b required 0", in_ready); end
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b required 0", out_valid); end
    n_cmp++; if (out_data !== '0) begin n_err++; $display("FAIL reset_out_data: got %h required 0", out_data); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b required 0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b required 0", done); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    c_len = 3; c_groups = 1; c_shift = 0; c_bias_en = 1; c_act = 0; c_sat = 1; c_mp = 0;
    ja = '{2, 3, 4}; jb = '{5, 6, 7}; jbias = '{10, 0, 0};
    run_job(0);
    n_cmp++; if (got_d.size() !== 1) begin n_err++; $display("FAIL basic_count: got %0d outputs required 1", got_d.size()); end
    if (got_d.size() > 0) begin
      n_cmp++; if (got_d[0] !== 16'd66) begin n_err++; $display("FAIL basic_data: got %0d required 66", $signed(got_d[0])); end
      n_cmp++; if (got_c[0] !== lastacc[0] + 4) begin n_err++; $display("FAIL basic_latency: got cycle %0d required %0d", got_c[0], lastacc[0] + 4); end
      n_cmp++; if (done_c.size() !== 1 || done_c[0] <= got_c[0]) begin n_err++; $display("FAIL basic_done_order: done count %0d, done after output required", done_c.size()); end
    end
  endtask

  task automatic test_activation();
    logic [OUT_W-1:0] want [3];
    want[0] = 16'hFFC0; want[1] = 16'hFFF8; want[2] = 16'h0000;
    for (int act = 0; act < 3; act++) begin
      c_len = 1; c_groups = 1; c_shift = 0; c_bias_en = 0; c_act = act; c_sat = 1; c_mp = 0;
      ja = '{-64}; jb = '{1}; jbias = '{0};
      run_job(0);
      n_cmp++;
      if (got_d.size() !== 1 || got_d[0] !== want[act]) begin
        n_err++; $display("FAIL act%0d: got %0d outputs first %h required %h", act, got_d.size(), got_d.size() > 0 ? got_d[0] : 16'hxxxx, want[act]);
      end
    end
  endtask

  task automatic test_saturation();
    logic [OUT_W-1:0] want [2];
    want[0] = 16'h0002; want[1] = 16'h7FFF;
    for (int s = 0; s < 2; s++) begin
      c_len = 2; c_groups = 1; c_shift = 0; c_bias_en = 0; c_act = 0; c_sat = s; c_mp = 0;
      ja = '{32767, 32767}; jb = '{32767, 32767}; jbias = '{0, 0};
      run_job(0);
      n_cmp++;
      if (got_d.size() !== 1 || got_d[0] !== want[s]) begin
        n_err++; $display("FAIL sat_en%0d: got %0d outputs first %h required %h", s, got_d.size(), got_d.size() > 0 ? got_d[0] : 16'hxxxx, want[s]);
      end
    end
  endtask

  task automatic test_shift();
    c_len = 1; c_groups = 1; c_shift = 2; c_bias_en = 0; c_act = 0; c_sat = 1; c_mp = 0;
    ja = '{-40}; jb = '{1}; jbias = '{0};
    run_job(0);
    n_cmp++;
    if (got_d.size() !== 1 || got_d[0] !== 16'hFFF6) begin
      n_err++; $display("FAIL shift_neg: got %0d outputs first %h required fff6", got_d.size(), got_d.size() > 0 ? got_d[0] : 16'hxxxx);
    end
    c_bias_en = 1;
    ja = '{0}; jb = '{0}; jbias = '{3};
    run_job(0);
    n_cmp++;
    if (got_d.size() !== 1 || got_d[0] !== 16'h0003) begin
      n_err++; $display("FAIL shift_bias: got %0d outputs first %h required 0003", got_d.size(), got_d.size() > 0 ? got_d[0] : 16'hxxxx);
    end
  endtask

  task automatic test_maxpool();
    c_len = 4; c_groups = 2; c_shift = 0; c_bias_en = 1; c_act = 0; c_sat = 1; c_mp = 1;
    ja = '{-5, 7, 3, 7, -9, -2, -4, -8};
    jb.delete(); jbias.delete();
    for (int i = 0; i < 8; i++) begin jb.push_back(rnd16()); jbias.push_back(rnd16()); end
    run_job(40);
    n_cmp++; if (got_d.size() !== 2) begin n_err++; $display("FAIL maxpool_count: got %0d outputs required 2", got_d.size()); end
    if (got_d.size() == 2) begin
      n_cmp++; if (got_d[0] !== 16'd7) begin n_err++; $display("FAIL maxpool_g0: got %h required 0007", got_d[0]); end
      n_cmp++; if (got_d[1] !== 16'hFFFE) begin n_err++; $display("FAIL maxpool_g1: got %h required fffe", got_d[1]); end
    end
    n_cmp++; if (ready_after !== 1'b0) begin n_err++; $display("FAIL maxpool_ready_drop: got %b required 0", ready_after); end
  endtask

  task automatic test_empty();
    c_len = 0; c_groups = 3; c_shift = 0; c_bias_en = 0; c_act = 0; c_sat = 0; c_mp = 0;
    start_run();
    n_cmp++; if (done !== 1'b1 || busy !== 1'b1) begin n_err++; $display("FAIL empty_done: done=%b busy=%b required 1 1", done, busy); end
    @(negedge clk);
    n_cmp++; if (done !== 1'b0 || busy !== 1'b0) begin n_err++; $display("FAIL empty_idle: done=%b busy=%b required 0 0", done, busy); end
    c_len = 2; c_groups = 0;
    ja.delete(); jb.delete(); jbias.delete();
    run_job(0);
    n_cmp++; if (got_d.size() !== 0 || done_c.size() !== 1) begin n_err++; $display("FAIL empty_groups: outputs %0d done pulses %0d required 0 1", got_d.size(), done_c.size()); end
  endtask

  task automatic test_back_to_back();
    c_len = 1; c_groups = 8; c_shift = 3; c_bias_en = 1; c_act = 0; c_sat = 0; c_mp = 0;
    ja.delete(); jb.delete(); jbias.delete();
    for (int i = 0; i < 8; i++) begin ja.push_back(rnd16()); jb.push_back(rnd16()); jbias.push_back(rnd16()); end
    build_exp();
    run_job(0);
    n_cmp++; if (got_d.size() !== 8) begin n_err++; $display("FAIL b2b_count: got %0d outputs required 8", got_d.size()); end
    for (int i = 0; i < 8 && i < got_d.size(); i++) begin
      n_cmp++; if (got_d[i] !== exp_q[i]) begin n_err++; $display("FAIL b2b_data[%0d]: got %h required %h", i, got_d[i], exp_q[i]); end
      n_cmp++; if (got_c[i] !== got_c[0] + i) begin n_err++; $display("FAIL b2b_rate[%0d]: got cycle %0d required %0d", i, got_c[i], got_c[0] + i); end
    end
  endtask

  task automatic test_abort();
    c_len = 4; c_groups = 2; c_shift = 0; c_bias_en = 0; c_act = 0; c_sat = 0; c_mp = 0;
    start_run();
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; op_a = DATA_W'(rnd16()); op_b = DATA_W'(rnd16());
      @(negedge clk);
    end
    in_valid = 1'b0; rst = 1'b1;
    @(negedge clk);
    got_d.delete(); done_c.delete();
    n_cmp++; if (busy !== 1'b0 || in_ready !== 1'b0) begin n_err++; $display("FAIL abort_idle: busy=%b in_ready=%b required 0 0", busy, in_ready); end
    rst = 1'b0;
    repeat (10) @(negedge clk);
    n_cmp++; if (got_d.size() !== 0 || done_c.size() !== 0) begin n_err++; $display("FAIL abort_quiet: outputs %0d done pulses %0d required 0 0", got_d.size(), done_c.size()); end
  endtask

  task automatic test_random();
    for (int job = 0; job < 8; job++) begin
      c_len = $urandom_range(1, 6); c_groups = $urandom_range(1, 3);
      c_shift = $urandom_range(0, 20); c_bias_en = $urandom_range(0, 1);
      c_act = $urandom_range(0, 3); c_sat = $urandom_range(0, 1); c_mp = $urandom_range(0, 1);
      ja.delete(); jb.delete(); jbias.delete();
      for (int i = 0; i < c_len * c_groups; i++) begin
        ja.push_back(rnd16()); jb.push_back(rnd16()); jbias.push_back(rnd16());
      end
      build_exp();
      run_job(30);
      n_cmp++; if (got_d.size() !== exp_q.size()) begin n_err++; $display("FAIL rand%0d_count: got %0d outputs required %0d", job, got_d.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size() && i < got_d.size(); i++) begin
        n_cmp++; if (got_d[i] !== exp_q[i]) begin n_err++; $display("FAIL rand%0d_data[%0d]: got %h required %h", job, i, got_d[i], exp_q[i]); end
        n_cmp++; if (got_c[i] !== lastacc[i] + 4) begin n_err++; $display("FAIL rand%0d_latency[%0d]: got cycle %0d required %0d", job, i, got_c[i], lastacc[i] + 4); end
      end
      n_cmp++;
      if (done_c.size() !== 1 || got_d.size() == 0 || done_c[0] <= got_c[got_d.size() - 1]) begin
        n_err++; $display("FAIL rand%0d_done: done pulses %0d, done after final output required", job, done_c.size());
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_activation();
    test_saturation();
    test_shift();
    test_maxpool();
    test_empty();
    test_back_to_back();
    test_abort();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
